sdrc_cmd_responder: RTL and testbench



---
 rtl/sdrc_cmd_responder_if.sv | 38 +++
 rtl/sdrc_cmd_responder.sv | 139 +++++++++++++
 tb/tb_sdrc_cmd_responder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/sdrc_cmd_responder_if.sv
// Command, write-FIFO, read-return and memory-port bundle for sdrc_cmd_responder.
// slave = responder side, master = issuer/memory side.
`ifndef EXT_BUF_MEM_ADDR_WIDTH
`define EXT_BUF_MEM_ADDR_WIDTH 16
`endif
`ifndef EXT_BUF_MEM_DATA_WIDTH
`define EXT_BUF_MEM_DATA_WIDTH 16
`endif

interface sdrc_cmd_responder_if #(
  parameter int ADDR_W = `EXT_BUF_MEM_ADDR_WIDTH,
  parameter int DATA_W = `EXT_BUF_MEM_DATA_WIDTH
);
  logic              sdrc_act;
  logic [ADDR_W+5:0] sdrc_cmd;
  logic              sdrc_ready;
  logic              sdrc_data_in_req;
  logic [DATA_W-1:0] sdrc_data_in;
  logic [DATA_W-1:0] sdrc_rd_data;
  logic              sdrc_rd_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  sdrc_act, sdrc_cmd, sdrc_data_in, mem_rdata,
    output sdrc_ready, sdrc_data_in_req, sdrc_rd_data, sdrc_rd_valid,
           mem_addr, mem_wr, mem_wdata, mem_rd
  );

  modport master (
    output sdrc_act, sdrc_cmd, sdrc_data_in, mem_rdata,
    input  sdrc_ready, sdrc_data_in_req, sdrc_rd_data, sdrc_rd_valid,
           mem_addr, mem_wr, mem_wdata, mem_rd
  );
endinterface

// File: rtl/sdrc_cmd_responder.sv
// Executes write/read bursts of 1..32 words on a fixed-latency memory port.
// Optional macro SDRC_RESP_PAGE_WRAP_EN: bursts wrap inside their 32-word page.
`ifndef EXT_BUF_MEM_ADDR_WIDTH
`define EXT_BUF_MEM_ADDR_WIDTH 16
`endif
`ifndef EXT_BUF_MEM_DATA_WIDTH
`define EXT_BUF_MEM_DATA_WIDTH 16
`endif

module sdrc_cmd_responder #(
  parameter int ADDR_W     = `EXT_BUF_MEM_ADDR_WIDTH,
  parameter int DATA_W     = `EXT_BUF_MEM_DATA_WIDTH,
  parameter int MEM_RD_LAT = 2
) (
  input  logic                sdrc_clk,
  input  logic                rst,
  sdrc_cmd_responder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    WR_BURST,
    WR_DRAIN,
    RD_ISSUE,
    RD_WAIT
  } state_t;

  localparam int VMSB = MEM_RD_LAT - 1;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_W-1:0]     base;
  logic [4:0]            len_m1;
  logic [4:0]            iss_cnt;
  logic [4:0]            wr_cnt;
  logic [4:0]            ret_cnt;
  logic                  wr_pend;
  logic                  ready_q;
  logic [MEM_RD_LAT-1:0] vld_sr;
  logic                  accept;
  logic                  req;
  logic                  rd;
  logic                  last_iss;
  logic                  last_ret;

  logic              cmd_wr;
  logic [4:0]        cmd_len;
  logic [ADDR_W-1:0] cmd_addr;

  assign cmd_wr   = bus.sdrc_cmd[ADDR_W+5];
  assign cmd_len  = bus.sdrc_cmd[ADDR_W+4:ADDR_W];
  assign cmd_addr = bus.sdrc_cmd[ADDR_W-1:0];

  assign last_iss = (iss_cnt == len_m1);
  assign last_ret = vld_sr[VMSB] && (ret_cnt == len_m1);

  function automatic logic [ADDR_W-1:0] burst_addr(input logic [ADDR_W-1:0] b,
                                                   input logic [4:0] i);
`ifdef SDRC_RESP_PAGE_WRAP_EN
    burst_addr = {b[ADDR_W-1:5], b[4:0] + i};
`else
    burst_addr = b + {{(ADDR_W-5){1'b0}}, i};
`endif
  endfunction

  always_ff @(posedge sdrc_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Commands are taken only while ready is visible, so the first cycle after reset release is ignored.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    req       = 1'b0;
    rd        = 1'b0;
    case (state)
      IDLE: begin
        if (ready_q && bus.sdrc_act) begin
          accept    = 1'b1;
          state_nxt = cmd_wr ? WR_BURST : RD_ISSUE;
        end
      end
      WR_BURST: begin
        req = 1'b1;
        if (last_iss) state_nxt = WR_DRAIN;
      end
      WR_DRAIN: state_nxt = IDLE;
      RD_ISSUE: begin
        rd = 1'b1;
        if (last_iss) state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (last_ret) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Each FIFO word lands one cycle after its request, so the write strobe is the request delayed.
  always_ff @(posedge sdrc_clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
      wr_pend <= 1'b0;
      vld_sr  <= '0;
      base    <= '0;
      len_m1  <= '0;
      iss_cnt <= '0;
      wr_cnt  <= '0;
      ret_cnt <= '0;
    end else begin
      ready_q <= (state_nxt == IDLE);
      wr_pend <= req;
      vld_sr  <= (vld_sr << 1) | MEM_RD_LAT'(rd);
      if (accept) begin
        base    <= cmd_addr;
        len_m1  <= cmd_len;
        iss_cnt <= '0;
        wr_cnt  <= '0;
        ret_cnt <= '0;
      end else begin
        if (req || rd)    iss_cnt <= iss_cnt + 5'd1;
        if (wr_pend)      wr_cnt  <= wr_cnt + 5'd1;
        if (vld_sr[VMSB]) ret_cnt <= ret_cnt + 5'd1;
      end
    end
  end

  assign bus.sdrc_ready       = ready_q;
  assign bus.sdrc_data_in_req = req;
  assign bus.mem_rd           = rd;
  assign bus.mem_wr           = wr_pend;
  assign bus.mem_wdata        = wr_pend ? bus.sdrc_data_in : '0;
  assign bus.mem_addr         = rd      ? burst_addr(base, iss_cnt) :
                                wr_pend ? burst_addr(base, wr_cnt)  : '0;
  assign bus.sdrc_rd_valid    = vld_sr[VMSB];
  assign bus.sdrc_rd_data     = bus.mem_rdata;

endmodule

// File: tb/tb_sdrc_cmd_responder.sv
// Bench for sdrc_cmd_responder: write-FIFO and memory models plus a cycle-level reference.
// Expected timing and addresses come from the burst rules, honouring SDRC_RESP_PAGE_WRAP_EN.
module tb_sdrc_cmd_responder;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 2;

  logic sdrc_clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  sdrc_cmd_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sdrc_cmd_responder #(.ADDR_W(AW), .DATA_W(DW), .MEM_RD_LAT(LAT)) dut (
    .sdrc_clk (sdrc_clk),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 sdrc_clk = ~sdrc_clk;

  function automatic logic [DW-1:0] init_pat(input int a);
    return DW'(a * 40503) ^ DW'(32'h5A5A);
  endfunction

  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] b, input int i);
    int bi = int'(b);
`ifdef SDRC_RESP_PAGE_WRAP_EN
    return AW'((bi / 32) * 32 + (bi % 32 + i) % 32);
`else
    return AW'((bi + i) % (1 << AW));
`endif
  endfunction

  // Write-data FIFO: word appears the cycle after each request.
  logic [DW-1:0] fifo_mem [256];
  int            fifo_wp = 0;
  int            fifo_rp = 0;
  bit            fifo_flush;

  always @(posedge sdrc_clk) begin
    if (fifo_flush) fifo_rp <= fifo_wp;
    else if (bus.sdrc_data_in_req) begin
      bus.sdrc_data_in <= fifo_mem[fifo_rp % 256];
      fifo_rp          <= fifo_rp + 1;
    end
  end

  // Memory model with LAT-cycle read latency; unwritten words hold init_pat.
  logic [DW-1:0] phy_mem [1<<AW];
  bit            phy_vld [1<<AW];
  logic [DW-1:0] rpipe   [LAT];
  logic [DW-1:0] ref_mem [1<<AW];

  always @(posedge sdrc_clk) begin
    if (bus.mem_wr) begin
      phy_mem[bus.mem_addr] <= bus.mem_wdata;
      phy_vld[bus.mem_addr] <= 1'b1;
    end
    rpipe[0] <= bus.mem_rd ? (phy_vld[bus.mem_addr] ? phy_mem[bus.mem_addr]
                                                    : init_pat(int'(bus.mem_addr))) : '0;
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end

  assign bus.mem_rdata = rpipe[LAT-1];

  task automatic check_output(input string tag, input int c,
                              input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle %0d observed=%h expected=%h", tag, c, obs, exp);
    end
  endtask

  // Entered and left at the negedge of a ready cycle, so commands run back-to-back.
  task automatic apply_stimulus(input bit wr, input int n, input logic [AW-1:0] base,
                                input bit inject, input int dmode);
    logic [DW-1:0] exp_d [32];
    int t;
    for (int i = 0; i < n; i++) begin
      exp_d[i] = (dmode == 1) ? DW'(i) : (dmode == 2) ? DW'(16'h00A5) : DW'($urandom);
      if (wr) begin
        fifo_mem[fifo_wp % 256] = exp_d[i];
        fifo_wp++;
        ref_mem[exp_addr(base, i)] = exp_d[i];
      end
    end
    t = wr ? n + 2 : n + LAT + 1;
    for (int c = 0; c <= t; c++) begin
      if (c > 0) @(negedge sdrc_clk);
      check_output("ready", c, 32'(bus.sdrc_ready), 32'(c == 0 || c == t));
      check_output("data_in_req", c, 32'(bus.sdrc_data_in_req), 32'(wr && c >= 1 && c <= n));
      check_output("mem_wr", c, 32'(bus.mem_wr), 32'(wr && c >= 2 && c <= n + 1));
      check_output("mem_rd", c, 32'(bus.mem_rd), 32'(!wr && c >= 1 && c <= n));
      check_output("rd_valid", c, 32'(bus.sdrc_rd_valid),
                   32'(!wr && c >= 1 + LAT && c <= n + LAT));
      if (wr && c >= 2 && c <= n + 1) begin
        check_output("wr_addr", c, 32'(bus.mem_addr), 32'(exp_addr(base, c - 2)));
        check_output("wr_data", c, 32'(bus.mem_wdata), 32'(exp_d[c-2]));
      end
      if (!wr && c >= 1 && c <= n)
        check_output("rd_addr", c, 32'(bus.mem_addr), 32'(exp_addr(base, c - 1)));
      if (!wr && c >= 1 + LAT && c <= n + LAT)
        check_output("rd_data", c, 32'(bus.sdrc_rd_data),
                     32'(ref_mem[exp_addr(base, c - 1 - LAT)]));
      if (c == 0) begin
        bus.sdrc_act = 1'b1;
        bus.sdrc_cmd = {wr, 5'(n - 1), base};
      end else if (inject && c == 2) begin
        bus.sdrc_act = 1'b1;
        bus.sdrc_cmd = (AW+6)'($urandom);
      end else begin
        bus.sdrc_act = 1'b0;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_ready"}, 0, 32'(bus.sdrc_ready), 32'd0);
    check_output({tag, "_req"}, 0, 32'(bus.sdrc_data_in_req), 32'd0);
    check_output({tag, "_valid"}, 0, 32'(bus.sdrc_rd_valid), 32'd0);
    check_output({tag, "_mem_wr"}, 0, 32'(bus.mem_wr), 32'd0);
    check_output({tag, "_mem_rd"}, 0, 32'(bus.mem_rd), 32'd0);
    check_output({tag, "_mem_addr"}, 0, 32'(bus.mem_addr), 32'd0);
    check_output({tag, "_mem_wdata"}, 0, 32'(bus.mem_wdata), 32'd0);
  endtask

  initial begin
    logic [DW-1:0]  rst_d [16];
    logic [AW-1:0]  last_base;
    bit             wr;
    int             n;
    logic [AW-1:0]  base;

    rst          = 1'b1;
    fifo_flush   = 1'b1;
    bus.sdrc_act = 1'b0;
    bus.sdrc_cmd = '0;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_pat(i);

    repeat (3) @(negedge sdrc_clk);
    check_all_zero("reset");
    rst        = 1'b0;
    fifo_flush = 1'b0;
    #1;
    check_output("ready_before_edge", 0, 32'(bus.sdrc_ready), 32'd0);
    @(negedge sdrc_clk);
    check_output("ready_after_release", 0, 32'(bus.sdrc_ready), 32'd1);

    apply_stimulus(1'b1, 1, 16'h0100, 1'b0, 2);
    apply_stimulus(1'b1, 32, 16'h0040, 1'b0, 1);
    apply_stimulus(1'b0, 1, 16'h0100, 1'b0, 0);
    apply_stimulus(1'b0, 32, 16'h0040, 1'b0, 0);
    apply_stimulus(1'b1, 4, 16'h003E, 1'b0, 0);
    apply_stimulus(1'b0, 4, 16'h003E, 1'b0, 0);
    apply_stimulus(1'b1, 8, 16'h1234, 1'b1, 0);
    apply_stimulus(1'b0, 8, 16'h1234, 1'b1, 0);

    // Reset in cycle 5 of a 16-word write: only the writes of cycles 2..4 reach memory.
    for (int i = 0; i < 16; i++) begin
      rst_d[i] = DW'($urandom);
      fifo_mem[fifo_wp % 256] = rst_d[i];
      fifo_wp++;
    end
    for (int i = 0; i < 3; i++) ref_mem[16'h8000 + i] = rst_d[i];
    bus.sdrc_act = 1'b1;
    bus.sdrc_cmd = {1'b1, 5'd15, 16'h8000};
    for (int c = 1; c <= 5; c++) begin
      @(negedge sdrc_clk);
      bus.sdrc_act = 1'b0;
    end
    check_output("mid_burst_req", 5, 32'(bus.sdrc_data_in_req), 32'd1);
    rst        = 1'b1;
    fifo_flush = 1'b1;
    #1;
    check_all_zero("mid_rst");
    repeat (2) @(negedge sdrc_clk);
    rst        = 1'b0;
    fifo_flush = 1'b0;
    #1;
    check_output("rst2_ready_before_edge", 0, 32'(bus.sdrc_ready), 32'd0);
    @(negedge sdrc_clk);
    check_output("rst2_ready_after_release", 0, 32'(bus.sdrc_ready), 32'd1);
    apply_stimulus(1'b0, 16, 16'h8000, 1'b0, 0);
    apply_stimulus(1'b1, 5, 16'hFFFE, 1'b0, 0);
    apply_stimulus(1'b0, 5, 16'hFFFE, 1'b0, 0);

    last_base = 16'h0040;
    for (int k = 0; k < 40; k++) begin
      wr   = 1'($urandom_range(0, 1));
      n    = $urandom_range(1, 32);
      base = (k % 3 == 0) ? last_base : AW'($urandom);
      apply_stimulus(wr, n, base, ($urandom_range(0, 3) == 0), 0);
      last_base = base;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule
